// File: rtl/sbox_pkg.sv
// Shared types and sizing helpers for the byte-substitution units.
package sbox_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sbox_state_e;

  // Number of byte lanes in a word of the given width.
  function automatic int nbytes(input int dataw);
    return dataw / 8;
  endfunction

  // Byte-index counter width; a single-lane word still gets a 1-bit counter.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int SBOX_DATAW  = 32;
  localparam int SBOX_NBYTES = nbytes(SBOX_DATAW);

endpackage

// File: rtl/inv_sbox_case.sv
// Combinational inverse substitution table; exact inverse permutation of sbox_case.
module inv_sbox_case
  import sbox_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // 256-entry inverse lookup
  always_comb begin
    data_o = 8'h00;
    case (data_i)
      8'h00: data_o = 8'h52; 8'h01: data_o = 8'h09; 8'h02: data_o = 8'h6a; 8'h03: data_o = 8'hd5; 8'h04: data_o = 8'h30; 8'h05: data_o = 8'h36; 8'h06: data_o = 8'ha5; 8'h07: data_o = 8'h38;
      8'h08: data_o = 8'hbf; 8'h09: data_o = 8'h40; 8'h0a: data_o = 8'ha3; 8'h0b: data_o = 8'h9e; 8'h0c: data_o = 8'h81; 8'h0d: data_o = 8'hf3; 8'h0e: data_o = 8'hd7; 8'h0f: data_o = 8'hfb;
      8'h10: data_o = 8'h7c; 8'h11: data_o = 8'he3; 8'h12: data_o = 8'h39; 8'h13: data_o = 8'h82; 8'h14: data_o = 8'h9b; 8'h15: data_o = 8'h2f; 8'h16: data_o = 8'hff; 8'h17: data_o = 8'h87;
      8'h18: data_o = 8'h34; 8'h19: data_o = 8'h8e; 8'h1a: data_o = 8'h43; 8'h1b: data_o = 8'h44; 8'h1c: data_o = 8'hc4; 8'h1d: data_o = 8'hde; 8'h1e: data_o = 8'he9; 8'h1f: data_o = 8'hcb;
      8'h20: data_o = 8'h54; 8'h21: data_o = 8'h7b; 8'h22: data_o = 8'h94; 8'h23: data_o = 8'h32; 8'h24: data_o = 8'ha6; 8'h25: data_o = 8'hc2; 8'h26: data_o = 8'h23; 8'h27: data_o = 8'h3d;
      8'h28: data_o = 8'hee; 8'h29: data_o = 8'h4c; 8'h2a: data_o = 8'h95; 8'h2b: data_o = 8'h0b; 8'h2c: data_o = 8'h42; 8'h2d: data_o = 8'hfa; 8'h2e: data_o = 8'hc3; 8'h2f: data_o = 8'h4e;
      8'h30: data_o = 8'h08; 8'h31: data_o = 8'h2e; 8'h32: data_o = 8'ha1; 8'h33: data_o = 8'h66; 8'h34: data_o = 8'h28; 8'h35: data_o = 8'hd9; 8'h36: data_o = 8'h24; 8'h37: data_o = 8'hb2;
      8'h38: data_o = 8'h76; 8'h39: data_o = 8'h5b; 8'h3a: data_o = 8'ha2; 8'h3b: data_o = 8'h49; 8'h3c: data_o = 8'h6d; 8'h3d: data_o = 8'h8b; 8'h3e: data_o = 8'hd1; 8'h3f: data_o = 8'h25;
      8'h40: data_o = 8'h72; 8'h41: data_o = 8'hf8; 8'h42: data_o = 8'hf6; 8'h43: data_o = 8'h64; 8'h44: data_o = 8'h86; 8'h45: data_o = 8'h68; 8'h46: data_o = 8'h98; 8'h47: data_o = 8'h16;
      8'h48: data_o = 8'hd4; 8'h49: data_o = 8'ha4; 8'h4a: data_o = 8'h5c; 8'h4b: data_o = 8'hcc; 8'h4c: data_o = 8'h5d; 8'h4d: data_o = 8'h65; 8'h4e: data_o = 8'hb6; 8'h4f: data_o = 8'h92;
      8'h50: data_o = 8'h6c; 8'h51: data_o = 8'h70; 8'h52: data_o = 8'h48; 8'h53: data_o = 8'h50; 8'h54: data_o = 8'hfd; 8'h55: data_o = 8'hed; 8'h56: data_o = 8'hb9; 8'h57: data_o = 8'hda;
      8'h58: data_o = 8'h5e; 8'h59: data_o = 8'h15; 8'h5a: data_o = 8'h46; 8'h5b: data_o = 8'h57; 8'h5c: data_o = 8'ha7; 8'h5d: data_o = 8'h8d; 8'h5e: data_o = 8'h9d; 8'h5f: data_o = 8'h84;
      8'h60: data_o = 8'h90; 8'h61: data_o = 8'hd8; 8'h62: data_o = 8'hab; 8'h63: data_o = 8'h00; 8'h64: data_o = 8'h8c; 8'h65: data_o = 8'hbc; 8'h66: data_o = 8'hd3; 8'h67: data_o = 8'h0a;
      8'h68: data_o = 8'hf7; 8'h69: data_o = 8'he4; 8'h6a: data_o = 8'h58; 8'h6b: data_o = 8'h05; 8'h6c: data_o = 8'hb8; 8'h6d: data_o = 8'hb3; 8'h6e: data_o = 8'h45; 8'h6f: data_o = 8'h06;
      8'h70: data_o = 8'hd0; 8'h71: data_o = 8'h2c; 8'h72: data_o = 8'h1e; 8'h73: data_o = 8'h8f; 8'h74: data_o = 8'hca; 8'h75: data_o = 8'h3f; 8'h76: data_o = 8'h0f; 8'h77: data_o = 8'h02;
      8'h78: data_o = 8'hc1; 8'h79: data_o = 8'haf; 8'h7a: data_o = 8'hbd; 8'h7b: data_o = 8'h03; 8'h7c: data_o = 8'h01; 8'h7d: data_o = 8'h13; 8'h7e: data_o = 8'h8a; 8'h7f: data_o = 8'h6b;
      8'h80: data_o = 8'h3a; 8'h81: data_o = 8'h91; 8'h82: data_o = 8'h11; 8'h83: data_o = 8'h41; 8'h84: data_o = 8'h4f; 8'h85: data_o = 8'h67; 8'h86: data_o = 8'hdc; 8'h87: data_o = 8'hea;
      8'h88: data_o = 8'h97; 8'h89: data_o = 8'hf2; 8'h8a: data_o = 8'hcf; 8'h8b: data_o = 8'hce; 8'h8c: data_o = 8'hf0; 8'h8d: data_o = 8'hb4; 8'h8e: data_o = 8'he6; 8'h8f: data_o = 8'h73;
      8'h90: data_o = 8'h96; 8'h91: data_o = 8'hac; 8'h92: data_o = 8'h74; 8'h93: data_o = 8'h22; 8'h94: data_o = 8'he7; 8'h95: data_o = 8'had; 8'h96: data_o = 8'h35; 8'h97: data_o = 8'h85;
      8'h98: data_o = 8'he2; 8'h99: data_o = 8'hf9; 8'h9a: data_o = 8'h37; 8'h9b: data_o = 8'he8; 8'h9c: data_o = 8'h1c; 8'h9d: data_o = 8'h75; 8'h9e: data_o = 8'hdf; 8'h9f: data_o = 8'h6e;
      8'ha0: data_o = 8'h47; 8'ha1: data_o = 8'hf1; 8'ha2: data_o = 8'h1a; 8'ha3: data_o = 8'h71; 8'ha4: data_o = 8'h1d; 8'ha5: data_o = 8'h29; 8'ha6: data_o = 8'hc5; 8'ha7: data_o = 8'h89;
      8'ha8: data_o = 8'h6f; 8'ha9: data_o = 8'hb7; 8'haa: data_o = 8'h62; 8'hab: data_o = 8'h0e; 8'hac: data_o = 8'haa; 8'had: data_o = 8'h18; 8'hae: data_o = 8'hbe; 8'haf: data_o = 8'h1b;
      8'hb0: data_o = 8'hfc; 8'hb1: data_o = 8'h56; 8'hb2: data_o = 8'h3e; 8'hb3: data_o = 8'h4b; 8'hb4: data_o = 8'hc6; 8'hb5: data_o = 8'hd2; 8'hb6: data_o = 8'h79; 8'hb7: data_o = 8'h20;
      8'hb8: data_o = 8'h9a; 8'hb9: data_o = 8'hdb; 8'hba: data_o = 8'hc0; 8'hbb: data_o = 8'hfe; 8'hbc: data_o = 8'h78; 8'hbd: data_o = 8'hcd; 8'hbe: data_o = 8'h5a; 8'hbf: data_o = 8'hf4;
      8'hc0: data_o = 8'h1f; 8'hc1: data_o = 8'hdd; 8'hc2: data_o = 8'ha8; 8'hc3: data_o = 8'h33; 8'hc4: data_o = 8'h88; 8'hc5: data_o = 8'h07; 8'hc6: data_o = 8'hc7; 8'hc7: data_o = 8'h31;
      8'hc8: data_o = 8'hb1; 8'hc9: data_o = 8'h12; 8'hca: data_o = 8'h10; 8'hcb: data_o = 8'h59; 8'hcc: data_o = 8'h27; 8'hcd: data_o = 8'h80; 8'hce: data_o = 8'hec; 8'hcf: data_o = 8'h5f;
      8'hd0: data_o = 8'h60; 8'hd1: data_o = 8'h51; 8'hd2: data_o = 8'h7f; 8'hd3: data_o = 8'ha9; 8'hd4: data_o = 8'h19; 8'hd5: data_o = 8'hb5; 8'hd6: data_o = 8'h4a; 8'hd7: data_o = 8'h0d;
      8'hd8: data_o = 8'h2d; 8'hd9: data_o = 8'he5; 8'hda: data_o = 8'h7a; 8'hdb: data_o = 8'h9f; 8'hdc: data_o = 8'h93; 8'hdd: data_o = 8'hc9; 8'hde: data_o = 8'h9c; 8'hdf: data_o = 8'hef;
      8'he0: data_o = 8'ha0; 8'he1: data_o = 8'he0; 8'he2: data_o = 8'h3b; 8'he3: data_o = 8'h4d; 8'he4: data_o = 8'hae; 8'he5: data_o = 8'h2a; 8'he6: data_o = 8'hf5; 8'he7: data_o = 8'hb0;
      8'he8: data_o = 8'hc8; 8'he9: data_o = 8'heb; 8'hea: data_o = 8'hbb; 8'heb: data_o = 8'h3c; 8'hec: data_o = 8'h83; 8'hed: data_o = 8'h53; 8'hee: data_o = 8'h99; 8'hef: data_o = 8'h61;
      8'hf0: data_o = 8'h17; 8'hf1: data_o = 8'h2b; 8'hf2: data_o = 8'h04; 8'hf3: data_o = 8'h7e; 8'hf4: data_o = 8'hba; 8'hf5: data_o = 8'h77; 8'hf6: data_o = 8'hd6; 8'hf7: data_o = 8'h26;
      8'hf8: data_o = 8'he1; 8'hf9: data_o = 8'h69; 8'hfa: data_o = 8'h14; 8'hfb: data_o = 8'h63; 8'hfc: data_o = 8'h55; 8'hfd: data_o = 8'h21; 8'hfe: data_o = 8'h0c; 8'hff: data_o = 8'h7d;
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/sbox_case.sv
// Forward substitution table, only built when INV_SBOX_FWD_CHECK_EN is defined
// (it exists here solely to re-check the inverse lookup).
`ifdef INV_SBOX_FWD_CHECK_EN
module sbox_case
  import sbox_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the packed table
  always_comb begin
    data_o = FWD_TABLE[(11'd2047 - {data_i, 3'b000}) -: 8];
  end

endmodule
`endif

// File: rtl/inv_sbox_seq.sv
// Sequential inverse byte substitution, one shared lookup, one byte per cycle.
// Optional forward re-check of every lookup: define INV_SBOX_FWD_CHECK_EN.
module inv_sbox_seq
  import sbox_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DATAW-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DATAW-1:0] data_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int NBYTES = nbytes(DATAW);
  localparam int IDXW   = idx_width(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  inv_sbox_state_e  state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [DATAW-1:0] src_q, src_d;
  logic [DATAW-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [IDXW-1:0]  lane_s;
  logic [IDXW+2:0]  shift_s;
  byte_t            src_byte_s;
  byte_t            inv_byte_s;
  logic             chk_err_s;

  // Pick the current source byte, MSB lane first
  always_comb begin
    lane_s     = LAST_IDX - idx_q;
    shift_s    = {lane_s, 3'b000};
    src_byte_s = byte_t'(src_q >> shift_s);
  end

  inv_sbox_case u_inv_case (
    .data_i (src_byte_s),
    .data_o (inv_byte_s)
  );

`ifdef INV_SBOX_FWD_CHECK_EN
  byte_t fwd_byte_s;

  sbox_case u_fwd_case (
    .data_i (inv_byte_s),
    .data_o (fwd_byte_s)
  );

  assign chk_err_s = (fwd_byte_s != src_byte_s);
`else
  assign chk_err_s = 1'b0;
`endif

  // Next-state, counter, datapath and output-flag logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    src_d       = src_q;
    res_d       = res_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d    = BUSY;
          src_d      = data_i;
          idx_d      = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        res_d = (res_q & ~({{(DATAW-8){1'b0}}, 8'hFF} << shift_s))
              | ({{(DATAW-8){1'b0}}, inv_byte_s} << shift_s);
        err_d = err_q | chk_err_s;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      src_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign data_o      = res_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_inv_sbox_seq.sv
// Directed bench for inv_sbox_seq (DATAW=32), with a forward-table model.
module tb_inv_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fwd [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] inv_m [256];

  inv_sbox_seq #(.DATAW(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Present one word from IDLE with out_ready high; lat counts edges after the
  // accepting edge until out_valid is seen (capped at 20 on a hang).
  task automatic send_word(input logic [31:0] w, output logic [31:0] r,
                           output logic e, output int lat);
    in_valid  = 1'b1;
    data_in   = w;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 32'hDEADBEEF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = data_out;
    e = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_in = 32'h0; out_ready = 1'b0;
    #12;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_out); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] r; logic e; int lat;
    send_word(32'h637C0116, r, e, lat);
    n_vec++; if (r !== 32'h000109FF) begin n_err++; $display("FAIL basic_data got %h want 000109FF", r); end
    // valid in the 5th cycle after the accept cycle = 4 edges after the accept edge
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL basic_err got %b want 0", e); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_patterns();
    logic [31:0] r; logic e; int lat;
    send_word(32'h00000000, r, e, lat);
    n_vec++; if (r !== 32'h52525252) begin n_err++; $display("FAIL zero_word got %h want 52525252", r); end
    // 0x52 is not its own inverse: the inverse table maps it to 0x48
    send_word(32'h52525252, r, e, lat);
    n_vec++; if (r !== 32'h48484848) begin n_err++; $display("FAIL non_involution got %h want 48484848", r); end
    send_word(32'h16016301, r, e, lat);
    n_vec++; if (r !== 32'hFF090009) begin n_err++; $display("FAIL lane_order got %h want FF090009", r); end
  endtask

  task automatic test_backpressure();
    int wait_n;
    in_valid = 1'b1; data_in = 32'h637C0116; out_ready = 1'b0;
    @(posedge clk); #1;
    data_in = 32'h00000000;   // second word held on the bus the whole time
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin @(posedge clk); #1; wait_n++; end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++; if (data_out !== 32'h000109FF || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold cyc %0d got data %h rdy %b vld %b want 000109FF 0 1", i, data_out, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release got rdy %b busy %b want 1 0", in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_second_accept got busy %b want 1", busy); end
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin @(posedge clk); #1; wait_n++; end
    n_vec++; if (data_out !== 32'h52525252) begin n_err++; $display("FAIL bp_second_data got %h want 52525252", data_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    logic [31:0] r; logic e; int lat; logic [7:0] b; logic [7:0] x;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      x = inv_m[i];
      send_word({b, b, b, b}, r, e, lat);
      n_vec++; if (r !== {x, x, x, x} || lat !== 4) begin
        n_err++; $display("FAIL exhaustive byte %h got %h lat %0d want %h lat 4", b, r, lat, {x, x, x, x});
      end
    end
  endtask

  task automatic test_compose();
    logic [31:0] w, s, r; logic e; int lat;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      s = {fwd[w[31:24]], fwd[w[23:16]], fwd[w[15:8]], fwd[w[7:0]]};
      send_word(s, r, e, lat);
      n_vec++; if (r !== w || e !== 1'b0) begin
        n_err++; $display("FAIL compose in %h got %h err %b want %h err 0", s, r, e, w);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; int lat; int wait_n;
    in_valid = 1'b1; data_in = 32'h637C0116; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;       // two bytes done, index now 2
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy_before got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_busy got busy %b vld %b rdy %b data %h want 0 0 1 0", busy, out_valid, in_ready, data_out);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(32'h16016301, r, e, lat);
    n_vec++; if (r !== 32'hFF090009 || lat !== 4) begin
      n_err++; $display("FAIL rst_recover got %h lat %0d want FF090009 lat 4", r, lat);
    end
    in_valid = 1'b1; data_in = 32'h00000000; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin @(posedge clk); #1; wait_n++; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_done got vld %b busy %b want 0 0", out_valid, busy);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef INV_SBOX_FWD_CHECK_EN
  task automatic test_err();
    logic [31:0] r; logic e; int lat;
    force u_dut.u_inv_case.data_o = 8'h00;
    send_word(32'h00000000, r, e, lat);
    release u_dut.u_inv_case.data_o;
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_forced got %b want 1", e); end
    send_word(32'h637C0116, r, e, lat);
    n_vec++; if (e !== 1'b0 || r !== 32'h000109FF) begin
      n_err++; $display("FAIL err_clean got err %b data %h want 0 000109FF", e, r);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) inv_m[fwd[i]] = 8'(i);
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_compose();
`ifdef INV_SBOX_FWD_CHECK_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
